mem_responder: RTL



---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_word_array.sv | 34 +++
 rtl/mem_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the unified memory responder:
//               FSM state encoding, wait-counter width and default sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wait-state counter width (supports WAIT_CYCLES 0..15)
    localparam int CNT_W = 4;

    // Default sizing
    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_WAIT_CYCLES = 2;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_word_array
// Description : Single-port word storage. Writes are synchronous to clk,
//               the read port follows the index combinationally so the
//               responder can capture read data on the completing edge.
//               Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_word_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    assign rdata = mem[index];

endmodule : mem_word_array
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Unified instruction/data memory responder for the multicycle
//               core. Accepts one request at a time, inserts WAIT_CYCLES wait
//               states, performs the access on the completing edge and
//               pulses resp_valid for one cycle, followed by a one-cycle
//               bubble before the next acceptance.
//               Optional macro MEM_ALIGN_CHK_EN adds resp_err and rejects
//               misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy
`ifdef MEM_ALIGN_CHK_EN
    ,
    output logic              resp_err
`endif
);

    localparam int              IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit              ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic              lat_mis;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_wdata;

    // Request fields seen by the access; live inputs only matter in IDLE
    // (zero-wait completion happens on the accepting edge itself).
    logic              acc_we;
    logic              acc_mis;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    logic              req_mis;
    logic              finish;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_addr;

`ifdef MEM_ALIGN_CHK_EN
    assign req_mis = |req_addr[1:0];
`else
    assign req_mis = 1'b0;
`endif

    // Upper address bits alias by design; low bits only matter with the check
    assign unused_addr = ^req_addr;

    // Select current access fields and detect the completing edge
    always_comb begin
        finish    = 1'b0;
        acc_we    = lat_we;
        acc_mis   = lat_mis;
        acc_idx   = lat_idx;
        acc_wdata = lat_wdata;
        if (state == IDLE) begin
            finish    = req_valid && ZERO_WAIT;
            acc_we    = req_we;
            acc_mis   = req_mis;
            acc_idx   = req_addr[IDX_W+1:2];
            acc_wdata = req_wdata;
        end else if (state == WAIT) begin
            finish    = (cnt == '0);
        end
    end

    // Writes are suppressed while reset is held so an aborted access never lands
    assign mem_we = finish && acc_we && !acc_mis && !reset;

    mem_word_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .index (acc_idx),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    // FSM, wait counter, request latch and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_mis    <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
`ifdef MEM_ALIGN_CHK_EN
            resp_err   <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
`ifdef MEM_ALIGN_CHK_EN
            resp_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_mis   <= req_mis;
                        lat_idx   <= req_addr[IDX_W+1:2];
                        lat_wdata <= req_wdata;
                        if (ZERO_WAIT) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (finish) begin
                resp_valid <= 1'b1;
                if (acc_mis) begin
                    resp_rdata <= '0;
`ifdef MEM_ALIGN_CHK_EN
                    resp_err   <= 1'b1;
`endif
                end else if (!acc_we) begin
                    resp_rdata <= mem_rdata;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule : mem_responder
`default_nettype wire
